// File: rtl/fsm_combin.sv
// Control unit for the simple CPU datapath: latches an instruction in T0 and
// sequences the bus/ALU control lines over up to three execute cycles.
module fsm_combin (
    input  logic        clk,
    input  logic        rst,
    input  logic        w,
    input  logic [11:0] instruction_F,
    output logic [3:0]  reg_x_num,
    output logic [3:0]  reg_y_num,
    output logic        A_in,
    output logic        G_in,
    output logic        G_out,
    output logic        Extern,
    output logic [1:0]  AddXor
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] OP_MV  = 4'b0001;
    localparam logic [3:0] OP_MVI = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;

    // Packed control word: {reg_x, reg_y, A_in, G_in, G_out, Extern, AddXor}
    localparam logic [13:0] CTRL_IDLE = {4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

    state_t      state;
    state_t      nxt_state;
    logic [11:0] ir;
    logic [11:0] nxt_ir;

    // Moore decode of a (state, IR) pair into the control word.
    function automatic logic [13:0] decode(input state_t st, input logic [11:0] instr);
        logic [3:0]  op;
        logic [3:0]  rx;
        logic [3:0]  ry;
        logic [13:0] c;
        op = instr[11:8];
        rx = instr[7:4];
        ry = instr[3:0];
        c  = CTRL_IDLE;
        case (st)
            T1: begin
                case (op)
                    OP_MV:  c = {rx, ry, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
                    OP_MVI: c = {rx, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
                    OP_ADD,
                    OP_XOR: c = {4'hF, rx, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
                    default: c = CTRL_IDLE;
                endcase
            end
            T2: begin
                if (op == OP_ADD)
                    c = {4'hF, ry, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
                else if (op == OP_XOR)
                    c = {4'hF, ry, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10};
            end
            T3: begin
                if (op == OP_ADD || op == OP_XOR)
                    c = {rx, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt_state = T0;
        nxt_ir    = ir;
        case (state)
            T0: begin
                if (w) begin
                    nxt_state = T1;
                    nxt_ir    = instruction_F;
                end
            end
            T1: begin
                if (ir[11:8] == OP_ADD || ir[11:8] == OP_XOR)
                    nxt_state = T2;
            end
            T2:      nxt_state = T3;
            default: nxt_state = T0;
        endcase
    end

    // Outputs are registered from the next state/IR so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= T0;
            ir    <= 12'h000;
            {reg_x_num, reg_y_num, A_in, G_in, G_out, Extern, AddXor} <= CTRL_IDLE;
        end else begin
            state <= nxt_state;
            ir    <= nxt_ir;
            {reg_x_num, reg_y_num, A_in, G_in, G_out, Extern, AddXor} <= decode(nxt_state, nxt_ir);
        end
    end

endmodule

// File: tb/tb_fsm_combin.sv
// Directed bench for fsm_combin: each step advances one clock and checks the
// full control word against hand-computed values.
module tb_fsm_combin;

    logic        clk;
    logic        rst;
    logic        w;
    logic [11:0] instruction_F;
    logic [3:0]  reg_x_num;
    logic [3:0]  reg_y_num;
    logic        A_in;
    logic        G_in;
    logic        G_out;
    logic        Extern;
    logic [1:0]  AddXor;

    int n_tests;
    int n_fail;

    fsm_combin dut (
        .clk           (clk),
        .rst           (rst),
        .w             (w),
        .instruction_F (instruction_F),
        .reg_x_num     (reg_x_num),
        .reg_y_num     (reg_y_num),
        .A_in          (A_in),
        .G_in          (G_in),
        .G_out         (G_out),
        .Extern        (Extern),
        .AddXor        (AddXor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected word: {x, y, A_in, G_in, G_out, Extern, AddXor}
    task automatic check(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                         input logic ea, input logic egi, input logic ego,
                         input logic ee, input logic [1:0] eop);
        logic [13:0] obs;
        logic [13:0] exp_w;
        obs   = {reg_x_num, reg_y_num, A_in, G_in, G_out, Extern, AddXor};
        exp_w = {ex, ey, ea, egi, ego, ee, eop};
        n_tests++;
        assert (obs === exp_w) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_w);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        w   = 1'b1;
        instruction_F = 12'h000;

        // Reset, with w high and an ADD on the input held off by rst
        step(); check_idle("reset");
        instruction_F = 12'h310;
        step(); check_idle("reset_hold_1");
        step(); check_idle("reset_hold_2");

        // MV R1 <- R0
        rst = 1'b0; w = 1'b1; instruction_F = 12'h110;
        step(); check("mv_t1", 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        w = 1'b0;
        step(); check_idle("mv_t0");

        // MVI R1 <- extern
        w = 1'b1; instruction_F = 12'h212;
        step(); check("mvi_t1", 4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        w = 1'b0;
        step(); check_idle("mvi_t0");

        // ADD R1, R2 with instruction_F changing mid-flight
        w = 1'b1; instruction_F = 12'h312;
        step(); check("add_t1", 4'hF, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        w = 1'b0;
        step(); check("add_t2", 4'hF, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        instruction_F = 12'h412;
        step(); check("add_t3", 4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        step(); check_idle("add_t0");

        // XOR R1, R2 with w held high during execution (ignored)
        w = 1'b1; instruction_F = 12'h412;
        step(); check("xor_t1", 4'hF, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(); check("xor_t2", 4'hF, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        step(); check("xor_t3", 4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        w = 1'b0;
        step(); check_idle("xor_t0");
        for (int i = 0; i < 3; i++) begin
            step(); check_idle("idle_w0");
        end

        // Back-to-back MV with w held: T1, T0, T1
        w = 1'b1; instruction_F = 12'h110;
        step(); check("b2b_t1a", 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(); check_idle("b2b_t0");
        step(); check("b2b_t1b", 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        w = 1'b0;
        step(); check_idle("b2b_end");

        // ADD with Rx == Ry
        w = 1'b1; instruction_F = 12'h355;
        step(); check("addsame_t1", 4'hF, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        w = 1'b0;
        step(); check("addsame_t2", 4'hF, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        step(); check("addsame_t3", 4'h5, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        step(); check_idle("addsame_t0");

        // Abort ADD in T2 with reset
        w = 1'b1; instruction_F = 12'h312;
        step(); check("abort_t1", 4'hF, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        w = 1'b0;
        step(); check("abort_t2", 4'hF, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        rst = 1'b1;
        step(); check_idle("abort_rst");
        rst = 1'b0;
        step(); check_idle("abort_after");

        // NOP lasts exactly one cycle: NOP(T1), T0, then MV(T1)
        w = 1'b1; instruction_F = 12'h712;
        step(); check_idle("nop_t1");
        instruction_F = 12'h110;
        step(); check_idle("nop_t0");
        step(); check("nop_next_mv", 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        w = 1'b0;
        step(); check_idle("final_t0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
